hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Pipeline interlock controller for the 5-stage processor. It owns every hazard that the MX/WX bypass network cannot resolve: load-use stalls, branch-taken flushes, and the multi-cycle mult/div interlock with its start/ready handshake to the multdiv unit. It sits beside the bypass logic in the decode/execute boundary and drives the hold/bubble/flush controls of the PC, FD, DX and XM latches.

## Interface
- MD_TIMEOUT, 64: max cycles in BUSY before abort; legal range 2..2^CNT_W-1
- CNT_W, 7: width of the mult/div cycle counter
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset sampled on rising edge
- irFD  in  32  instruction in FD latch
- irDX  in  32  instruction in DX latch
- flushBranch  in  1  branch/jump in DX resolved taken this cycle
- data_resultRDY  in  1  multdiv result valid (level, one cycle)
- data_exception  in  1  multdiv exception, qualified by data_resultRDY
- stallPC, stallFD, stallDX  out  1 each  hold the corresponding register
- bubbleDX, bubbleXM, flushFD  out  1 each  load nop (32'b0) into that latch
- ctrl_MULT, ctrl_DIV  out  1 each  one-cycle start pulse to multdiv
- mdDone  out  1  XM latches multdiv result this cycle
- mdExc  out  1  mdDone with exception (data_exception or timeout)
- mdBusy  out  1  FSM not IDLE

## Operation
- Decode fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
- Sources read by FD instruction: R-type (00000) rs, rt; addi 00101 rs; lw 01000 rs; sw 00111 rd, rs; bne 00010 / blt 00110 rd, rs; jr 00100 rd; bex 10110 r30; j/jal/setx none.
- Mult/div: opcode 00000 with aluop 00110 (mul) or 00111 (div).
- Load-use: irDX is lw, rd != 0, rd equals any source of irFD -> stallPC, stallFD, bubbleDX for that cycle.
- Flush: flushBranch -> flushFD, bubbleDX; stallPC=0.
- Priority: mult/div stall > flush > load-use. Flush suppresses a coincident load-use stall.
- FSM states IDLE, BUSY; counter cnt.
- IDLE with mul/div in irDX: ctrl_MULT or ctrl_DIV high this cycle; stallPC, stallFD, stallDX, bubbleXM high; next state BUSY, cnt<=1.
- BUSY, data_resultRDY=0, cnt < MD_TIMEOUT: stalls and bubbleXM held; cnt increments.
- BUSY, data_resultRDY=1: mdDone=1, mdExc=data_exception; all stalls and bubbleXM low so DX advances into XM; next IDLE, cnt<=0.
- BUSY, cnt == MD_TIMEOUT without ready: mdDone=1, mdExc=1, stalls released; next IDLE.
- data_resultRDY in IDLE ignored. Start pulses never asserted in BUSY.
- Back-to-back mul/div: second is started in the cycle after mdDone (IDLE again, new irDX).

## Timing
- Reset: state IDLE, cnt 0; while reset high every output is 0.
- All outputs combinational from state, cnt and inputs; state and cnt registered.
- Load-use costs exactly 1 stall cycle; flush costs 2 squashed slots, 0 stall cycles.
- Mult/div occupancy: start cycle + N BUSY cycles, where ready arrives N cycles after the start pulse (N >= 1); DX held N+1 cycles inclusive of the release cycle.
- Reset mid-BUSY: next cycle IDLE, no mdDone, no start pulse; multdiv must be re-issued by the restarted program.
- Counter never wraps: MD_TIMEOUT < 2^CNT_W.

## Test plan
- lw r5 in DX, add r3,r5,r2 in FD -> one cycle stallPC=stallFD=bubbleDX=1, then 0; with lw r0 target -> no stall.
- lw r5 in DX, sw r5,0(r1) in FD (rd source) -> stall 1 cycle; lw r5 with j in FD -> no stall.
- flushBranch=1 coincident with load-use match -> flushFD=bubbleDX=1, stallPC=stallFD=0.
- mul in DX, data_resultRDY 17 cycles after ctrl_MULT pulse -> ctrl_MULT exactly 1 cycle, stalls/bubbleXM 17 cycles, mdDone=1 in cycle 18, mdExc=data_exception.
- div with ready never asserted, MD_TIMEOUT=64 -> mdDone=mdExc=1 in the 64th BUSY cycle, IDLE after; div then mul back-to-back -> second start pulse one cycle after first mdDone.
- reset asserted on 5th BUSY cycle -> all outputs 0 during reset, IDLE after, later stray data_resultRDY produces no mdDone.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock controller: load-use stall, taken-branch flush and the
// multi-cycle mult/div interlock with its start/ready handshake to multdiv.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] irFD,
  input  logic [31:0] irDX,
  input  logic        flushBranch,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  output logic        stallPC,
  output logic        stallFD,
  output logic        stallDX,
  output logic        bubbleDX,
  output logic        bubbleXM,
  output logic        flushFD,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        mdDone,
  output logic        mdExc,
  output logic        mdBusy
);

  localparam logic [4:0] OP_RTYPE   = 5'b00000;
  localparam logic [4:0] OP_ADDI    = 5'b00101;
  localparam logic [4:0] OP_LW      = 5'b01000;
  localparam logic [4:0] OP_SW      = 5'b00111;
  localparam logic [4:0] OP_BNE     = 5'b00010;
  localparam logic [4:0] OP_BLT     = 5'b00110;
  localparam logic [4:0] OP_JR      = 5'b00100;
  localparam logic [4:0] OP_BEX     = 5'b10110;
  localparam logic [4:0] ALU_MUL    = 5'b00110;
  localparam logic [4:0] ALU_DIV    = 5'b00111;
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam int         NUM_SRC    = 2;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} mdState_t;

  mdState_t         stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;

  // Field decode
  logic [4:0] fdOp, fdRd, fdRs, fdRt;
  logic [4:0] dxOp, dxRd, dxAluOp;
  assign fdOp    = irFD[31:27];
  assign fdRd    = irFD[26:22];
  assign fdRs    = irFD[21:17];
  assign fdRt    = irFD[16:12];
  assign dxOp    = irDX[31:27];
  assign dxRd    = irDX[26:22];
  assign dxAluOp = irDX[6:2];

  logic unusedBits;
  assign unusedBits = ^{irFD[11:0], irDX[21:7], irDX[1:0]};

  logic dxIsLw, dxIsMd, dxIsMul;
  assign dxIsLw  = (dxOp == OP_LW);
  assign dxIsMul = (dxOp == OP_RTYPE) && (dxAluOp == ALU_MUL);
  assign dxIsMd  = dxIsMul || ((dxOp == OP_RTYPE) && (dxAluOp == ALU_DIV));

  // Registers read by the FD instruction (at most two per opcode)
  logic [4:0]         srcReg [NUM_SRC];
  logic [NUM_SRC-1:0] srcVld;
  logic [NUM_SRC-1:0] srcHit;

  always_comb begin
    srcReg[0] = fdRs;
    srcReg[1] = fdRt;
    srcVld    = '0;
    case (fdOp)
      OP_RTYPE: srcVld = 2'b11;
      OP_ADDI,
      OP_LW:    srcVld = 2'b01;
      OP_SW,
      OP_BNE,
      OP_BLT: begin
        srcReg[1] = fdRd;
        srcVld    = 2'b11;
      end
      OP_JR: begin
        srcReg[0] = fdRd;
        srcVld    = 2'b01;
      end
      OP_BEX: begin
        srcReg[0] = REG_STATUS;
        srcVld    = 2'b01;
      end
      default: srcVld = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : gSrcHit
      assign srcHit[gi] = srcVld[gi] && (srcReg[gi] == dxRd);
    end
  endgenerate

  logic loadUse;
  assign loadUse = dxIsLw && (dxRd != 5'd0) && (|srcHit);

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  logic mdHold;

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    mdHold    = 1'b0;
    stallPC   = 1'b0;
    stallFD   = 1'b0;
    stallDX   = 1'b0;
    bubbleDX  = 1'b0;
    bubbleXM  = 1'b0;
    flushFD   = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    mdDone    = 1'b0;
    mdExc     = 1'b0;
    mdBusy    = 1'b0;

    case (stateReg)
      IDLE: begin
        if (dxIsMd) begin
          ctrl_MULT = dxIsMul;
          ctrl_DIV  = !dxIsMul;
          mdHold    = 1'b1;
          stateNext = BUSY;
          cntNext   = CNT_ONE;
        end
      end
      BUSY: begin
        mdBusy = 1'b1;
        // A ready in the timeout cycle still reports the unit's own exception
        if (data_resultRDY) begin
          mdDone    = 1'b1;
          mdExc     = data_exception;
          stateNext = IDLE;
          cntNext   = '0;
        end else if (cntReg >= CNT_LIMIT) begin
          mdDone    = 1'b1;
          mdExc     = 1'b1;
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          mdHold  = 1'b1;
          cntNext = cntReg + CNT_ONE;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase

    if (mdHold) begin
      stallPC  = 1'b1;
      stallFD  = 1'b1;
      stallDX  = 1'b1;
      bubbleXM = 1'b1;
    end else if (flushBranch) begin
      flushFD  = 1'b1;
      bubbleDX = 1'b1;
    end else if (loadUse) begin
      stallPC  = 1'b1;
      stallFD  = 1'b1;
      bubbleDX = 1'b1;
    end

    // Outputs are quiet for the whole reset cycle, including mid-BUSY
    if (reset) begin
      stallPC   = 1'b0;
      stallFD   = 1'b0;
      stallDX   = 1'b0;
      bubbleDX  = 1'b0;
      bubbleXM  = 1'b0;
      flushFD   = 1'b0;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      mdDone    = 1'b0;
      mdExc     = 1'b0;
      mdBusy    = 1'b0;
    end
  end

endmodule
